// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arbiter
// Purpose  : Two-master / one-slave Wishbone arbiter. It grants one master
//            for its whole cyc window, routes ack/err/read data to the owner
//            only, and aborts strobes the slave never acknowledges.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  // data master (m0)
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // instruction master (m1)
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // shared slave bus
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  // status
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Last wait-counter value before the strobe is aborted.
  localparam logic [15:0] c_to_last = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
  localparam logic        c_to_en   = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;   // 0 = m0 owned last, 1 = m1
  logic [15:0] wait_q, wait_d;

  logic            w_granted;
  logic            w_sel1;
  logic            w_cyc, w_stb, w_we;
  logic [DW/8-1:0] w_sel;
  logic [AW-1:0]   w_adr;
  logic [DW-1:0]   w_dat;
  logic            w_timeout;

  // Select the owning master's request signals and detect an unanswered strobe.
  always_comb begin
    w_granted = (state_q == GNT0) || (state_q == GNT1);
    w_sel1    = (state_q == GNT1);
    w_cyc     = w_sel1 ? m1_cyc_i : m0_cyc_i;
    w_stb     = w_sel1 ? m1_stb_i : m0_stb_i;
    w_we      = w_sel1 ? m1_we_i  : m0_we_i;
    w_sel     = w_sel1 ? m1_sel_i : m0_sel_i;
    w_adr     = w_sel1 ? m1_adr_i : m0_adr_i;
    w_dat     = w_sel1 ? m1_dat_i : m0_dat_i;
    // An ack arriving in the timeout cycle takes precedence over the abort.
    w_timeout = c_to_en && w_granted && w_cyc && w_stb && !s_ack_i && (wait_q == c_to_last);
  end

  // Arbitration, grant release and wait-counter next state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_d       = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          // Round-robin favours whoever did not own the bus last.
          if ((FIXED_PRIO != 0) || last_grant_q) begin
            state_d      = GNT0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GNT1;
            last_grant_d = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!w_cyc) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (s_ack_i || w_timeout) begin
          wait_d = '0;
        end else if (w_stb) begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // State, last-grant and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
    end
  end

  // Drive the slave bus from the owner and return responses to the owner only.
  always_comb begin
    s_cyc_o   = w_granted && w_cyc;
    s_stb_o   = w_granted && w_stb && !w_timeout;
    s_we_o    = w_granted && w_we;
    s_sel_o   = w_granted ? w_sel : '0;
    s_adr_o   = w_granted ? w_adr : '0;
    s_dat_o   = w_granted ? w_dat : '0;
    m0_ack_o  = (state_q == GNT0) && s_ack_i;
    m1_ack_o  = (state_q == GNT1) && s_ack_i;
    m0_err_o  = (state_q == GNT0) && w_timeout;
    m1_err_o  = (state_q == GNT1) && w_timeout;
    m0_dat_o  = (state_q == GNT0) ? s_dat_i : '0;
    m1_dat_o  = (state_q == GNT1) ? s_dat_i : '0;
    grant_o   = {state_q == GNT1, state_q == GNT0};
    timeout_o = w_timeout;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_arbiter
// Purpose  : Self-checking bench for wb_master_arbiter. Two instances share
//            all inputs: index 0 is round-robin with an 8-cycle timeout,
//            index 1 is fixed priority with the timeout disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_arbiter;

  logic clk;
  logic rst;

  logic [1:0]       m_cyc, m_stb, m_we;
  logic [1:0][3:0]  m_sel;
  logic [1:0][31:0] m_adr, m_dat;
  logic [31:0]      s_dat;
  logic             s_ack;

  logic [1:0][31:0] o_m0_dat, o_m1_dat, o_s_adr, o_s_dat;
  logic [1:0][3:0]  o_s_sel;
  logic [1:0]       o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [1:0]       o_s_cyc, o_s_stb, o_s_we, o_tmo;
  logic [1:0][1:0]  o_grant;

  int n_checks = 0;
  int n_fail   = 0;

  wb_master_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(o_m0_dat[0]),
    .m0_ack_o(o_m0_ack[0]), .m0_err_o(o_m0_err[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(o_m1_dat[0]),
    .m1_ack_o(o_m1_ack[0]), .m1_err_o(o_m1_err[0]),
    .s_cyc_o(o_s_cyc[0]), .s_stb_o(o_s_stb[0]), .s_we_o(o_s_we[0]), .s_sel_o(o_s_sel[0]),
    .s_adr_o(o_s_adr[0]), .s_dat_o(o_s_dat[0]), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(o_grant[0]), .timeout_o(o_tmo[0])
  );

  wb_master_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(o_m0_dat[1]),
    .m0_ack_o(o_m0_ack[1]), .m0_err_o(o_m0_err[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(o_m1_dat[1]),
    .m1_ack_o(o_m1_ack[1]), .m1_err_o(o_m1_err[1]),
    .s_cyc_o(o_s_cyc[1]), .s_stb_o(o_s_stb[1]), .s_we_o(o_s_we[1]), .s_sel_o(o_s_sel[1]),
    .s_adr_o(o_s_adr[1]), .s_dat_o(o_s_dat[1]), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant_o(o_grant[1]), .timeout_o(o_tmo[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    s_dat = '0; s_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the first clock edge out of reset.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  function automatic logic [10:0] ctl(int p);
    return {o_grant[p], o_s_cyc[p], o_s_stb[p], o_s_we[p], o_m0_ack[p], o_m1_ack[p],
            o_m0_err[p], o_m1_err[p], o_tmo[p], |o_s_adr[p]};
  endfunction

  task automatic test_reset();
    clear_inputs();
    m_cyc = 2'b11; m_stb = 2'b11; m_adr[0] = 32'hABCD; s_ack = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (ctl(p) !== 11'd0) begin
        n_fail++; $display("FAIL reset_outputs[%0d]: got %b required 0", p, ctl(p));
      end
    end
    @(posedge clk); @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (ctl(p) !== 11'd0) begin
        n_fail++; $display("FAIL reset_held[%0d]: got %b required 0", p, ctl(p));
      end
    end
  endtask

  task automatic test_single_m0();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if ({o_grant[p], o_s_cyc[p]} !== 3'b000) begin
        n_fail++; $display("FAIL single_latency[%0d]: got %b required 000", p, {o_grant[p], o_s_cyc[p]});
      end
    end
    step();
    s_ack = 1'b1; s_dat = 32'h12345678;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if ({o_grant[p], o_s_cyc[p], o_m0_ack[p], o_m1_ack[p]} !== 5'b01110 ||
          o_s_adr[p] !== 32'h100 || o_m0_dat[p] !== 32'h12345678 || o_m1_dat[p] !== 32'h0) begin
        n_fail++;
        $display("FAIL single_grant[%0d]: got gnt=%b cyc=%b ack0=%b ack1=%b adr=%h d0=%h d1=%h required 01 1 1 0 100 12345678 0",
                 p, o_grant[p], o_s_cyc[p], o_m0_ack[p], o_m1_ack[p], o_s_adr[p], o_m0_dat[p], o_m1_dat[p]);
      end
    end
    clear_inputs();
    step(); step();
  endtask

  task automatic test_rr_handover();
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clk);
    step(); @(negedge clk);
    n_checks++;
    if (o_grant[0] !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b required 01", o_grant[0]); end
    step(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0; @(negedge clk);
    n_checks++;
    if ({o_grant[0], o_s_cyc[0]} !== 3'b010) begin
      n_fail++; $display("FAIL rr_drop: got %b required 010", {o_grant[0], o_s_cyc[0]});
    end
    step(); @(negedge clk);
    n_checks++;
    if (o_grant[0] !== 2'b00) begin n_fail++; $display("FAIL rr_gap0: got %b required 00", o_grant[0]); end
    step(); s_ack = 1'b1; s_dat = 32'hCAFEF00D; @(negedge clk);
    n_checks++;
    if ({o_grant[0], o_m1_ack[0], o_m0_ack[0]} !== 4'b1010 || o_m1_dat[0] !== 32'hCAFEF00D || o_m0_dat[0] !== 32'h0) begin
      n_fail++; $display("FAIL rr_m1: got gnt=%b ack1=%b ack0=%b d1=%h d0=%h required 10 1 0 cafef00d 0",
                         o_grant[0], o_m1_ack[0], o_m0_ack[0], o_m1_dat[0], o_m0_dat[0]);
    end
    step(); s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01; @(negedge clk);
    step(); @(negedge clk);
    n_checks++;
    if (o_grant[0] !== 2'b00) begin n_fail++; $display("FAIL rr_gap1: got %b required 00", o_grant[0]); end
    step(); @(negedge clk);
    n_checks++;
    if (o_grant[0] !== 2'b01) begin n_fail++; $display("FAIL rr_back_m0: got %b required 01", o_grant[0]); end
    clear_inputs();
    step(); step();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    step(); @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if (o_grant[1] !== 2'b01) begin n_fail++; $display("FAIL fp_round%0d: got %b required 01", r, o_grant[1]); end
      step(); m_cyc[0] = 1'b0;
      step(); m_cyc[0] = 1'b1; @(negedge clk);
      n_checks++;
      if (o_grant[1] !== 2'b00) begin n_fail++; $display("FAIL fp_idle%0d: got %b required 00", r, o_grant[1]); end
      step(); @(negedge clk);
    end
    step(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step(); step(); @(negedge clk);
    n_checks++;
    if (o_grant[1] !== 2'b10) begin n_fail++; $display("FAIL fp_m1_alone: got %b required 10", o_grant[1]); end
    clear_inputs();
    step(); step();
  endtask

  task automatic test_timeout();
    logic e;
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(); @(negedge clk);
      e = ((k % 8) == 0);
      n_checks++;
      if ({o_m0_err[0], o_tmo[0], o_s_stb[0], o_m1_err[0]} !== {e, e, ~e, 1'b0}) begin
        n_fail++; $display("FAIL timeout_k%0d: got err/tmo/stb/err1=%b required %b",
                           k, {o_m0_err[0], o_tmo[0], o_s_stb[0], o_m1_err[0]}, {e, e, ~e, 1'b0});
      end
      n_checks++;
      if ({o_m0_err[1], o_tmo[1], o_s_stb[1]} !== 3'b001) begin
        n_fail++; $display("FAIL timeout_disabled_k%0d: got %b required 001", k, {o_m0_err[1], o_tmo[1], o_s_stb[1]});
      end
    end
    clear_inputs();
    step(); step();
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(); s_ack = (k == 8); @(negedge clk);
      if (k == 8) begin
        n_checks++;
        if ({o_m0_ack[0], o_m0_err[0], o_tmo[0], o_s_stb[0]} !== 4'b1001) begin
          n_fail++; $display("FAIL ack_wins: got ack/err/tmo/stb=%b required 1001",
                             {o_m0_ack[0], o_m0_err[0], o_tmo[0], o_s_stb[0]});
        end
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step(); s_ack = 1'b0; @(negedge clk);
      n_checks++;
      if (o_m0_err[0] !== (k == 8)) begin
        n_fail++; $display("FAIL after_ack_k%0d: got err=%b required %b", k, o_m0_err[0], (k == 8));
      end
    end
    clear_inputs();
    step(); step();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h2000;
    step(); @(negedge clk);
    n_checks++;
    if ({o_grant[0], o_s_cyc[0]} !== 3'b101) begin
      n_fail++; $display("FAIL areset_pre: got %b required 101", {o_grant[0], o_s_cyc[0]});
    end
    #1 rst = 1'b0;
    #1;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (ctl(p) !== 11'd0) begin
        n_fail++; $display("FAIL areset_now[%0d]: got %b required 0", p, ctl(p));
      end
    end
    m_cyc = 2'b11; m_stb = 2'b11;
    @(negedge clk);
    n_checks++;
    if (o_grant[0] !== 2'b00) begin n_fail++; $display("FAIL areset_hold: got %b required 00", o_grant[0]); end
    #1 rst = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (o_grant[p] !== 2'b01) begin n_fail++; $display("FAIL areset_m0_first[%0d]: got %b required 01", p, o_grant[p]); end
    end
    clear_inputs();
    step(); step();
  endtask

  // Random traffic against an ownership/wait-count model of the arbiter rules.
  task automatic test_random();
    int own[2], lastg[2], wcnt[2], to_lim[2], pick, oi;
    bit fp[2], gr, tmo;
    logic [9:0]  exp_ctl, act_ctl;
    logic [67:0] exp_bus, act_bus;
    logic [63:0] exp_rd, act_rd;
    do_reset();
    to_lim[0] = 8; to_lim[1] = 0; fp[0] = 1'b0; fp[1] = 1'b1;
    for (int p = 0; p < 2; p++) begin own[p] = -1; lastg[p] = 1; wcnt[p] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        m_cyc[m] = ($urandom_range(0, 7) != 0);
        m_stb[m] = m_cyc[m] && ($urandom_range(0, 4) != 0);
        m_we[m]  = $urandom_range(0, 1) != 0;
        m_sel[m] = 4'($urandom);
        m_adr[m] = $urandom;
        m_dat[m] = $urandom;
      end
      s_ack = ($urandom_range(0, 5) == 0);
      s_dat = $urandom;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        gr  = (own[p] >= 0);
        oi  = gr ? own[p] : 0;
        tmo = gr && m_cyc[oi] && m_stb[oi] && !s_ack && (to_lim[p] != 0) && (wcnt[p] == to_lim[p] - 1);
        exp_ctl = {gr && oi == 1, gr && oi == 0, gr && m_cyc[oi], gr && m_stb[oi] && !tmo, gr && m_we[oi],
                   gr && oi == 0 && s_ack, gr && oi == 1 && s_ack, gr && oi == 0 && tmo, gr && oi == 1 && tmo, tmo};
        act_ctl = {o_grant[p], o_s_cyc[p], o_s_stb[p], o_s_we[p], o_m0_ack[p], o_m1_ack[p],
                   o_m0_err[p], o_m1_err[p], o_tmo[p]};
        exp_bus = gr ? {m_sel[oi], m_adr[oi], m_dat[oi]} : 68'd0;
        act_bus = {o_s_sel[p], o_s_adr[p], o_s_dat[p]};
        exp_rd  = {(gr && oi == 0) ? s_dat : 32'd0, (gr && oi == 1) ? s_dat : 32'd0};
        act_rd  = {o_m0_dat[p], o_m1_dat[p]};
        n_checks++;
        if (act_ctl !== exp_ctl) begin
          n_fail++; $display("FAIL rand_ctl[%0d] cyc %0d: got %b required %b", p, c, act_ctl, exp_ctl);
        end
        n_checks++;
        if (act_bus !== exp_bus || act_rd !== exp_rd) begin
          n_fail++; $display("FAIL rand_data[%0d] cyc %0d: got %h/%h required %h/%h", p, c, act_bus, act_rd, exp_bus, exp_rd);
        end
        if (!gr) begin
          if (m_cyc[0] && m_cyc[1]) pick = (fp[p] || lastg[p] == 1) ? 0 : 1;
          else if (m_cyc[0])        pick = 0;
          else if (m_cyc[1])        pick = 1;
          else                      pick = -1;
          if (pick >= 0) begin own[p] = pick; lastg[p] = pick; end
          wcnt[p] = 0;
        end else if (!m_cyc[oi]) begin
          own[p] = -1; wcnt[p] = 0;
        end else if (s_ack || tmo) begin
          wcnt[p] = 0;
        end else if (m_stb[oi]) begin
          wcnt[p]++;
        end
      end
      step();
    end
    clear_inputs();
    step(); step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_m0();
    test_rr_handover();
    test_fixed_prio();
    test_timeout();
    test_ack_at_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
